// File: rtl/mxv_load_sequencer_pkg.sv
// Shared definitions for the matrix-vector load sequencer: FSM states,
// frame command codes, error codes and the payload-length helper.
package mxv_load_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_SIZE,
    LOAD_MAT,
    LOAD_VEC,
    GET_TRL,
    RUN
  } state_t;

  localparam logic [7:0] CMD_SIZE  = 8'h01;
  localparam logic [7:0] CMD_MAT   = 8'h02;
  localparam logic [7:0] CMD_VEC   = 8'h03;
  localparam logic [7:0] CMD_START = 8'h04;
  localparam logic [7:0] CMD_CLR   = 8'h05;

  localparam logic [2:0] ERR_BAD_CMD    = 3'd1;
  localparam logic [2:0] ERR_NO_SIZE    = 3'd2;
  localparam logic [2:0] ERR_BAD_SIZE   = 3'd3;
  localparam logic [2:0] ERR_NOT_LOADED = 3'd4;
  localparam logic [2:0] ERR_BAD_TRL    = 3'd5;
  localparam logic [2:0] ERR_BUSY       = 3'd6;

  // Matrix payload length N*N; fits 7 bits for any N up to 11.
  function automatic logic [6:0] mat_target(input logic [3:0] n);
    logic [7:0] sq;
    sq = {4'b0000, n} * {4'b0000, n};
    return sq[6:0];
  endfunction

endpackage

// File: rtl/mxv_load_sequencer_if.sv
// Byte stream, feeder control and compute handshake of the load sequencer.
interface mxv_load_sequencer_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       comp_done;
  logic [7:0] rec_data;
  logic       size_m_en;
  logic       enable_mat;
  logic       enable_vec;
  logic       enb_assign;
  logic       clear;
  logic       comp_start;
  logic       busy;
  logic       err;
  logic [2:0] err_code;

  modport master (
    input  rx_valid, rx_data, comp_done,
    output rec_data, size_m_en, enable_mat, enable_vec, enb_assign,
           clear, comp_start, busy, err, err_code
  );

  modport slave (
    output rx_valid, rx_data, comp_done,
    input  rec_data, size_m_en, enable_mat, enable_vec, enb_assign,
           clear, comp_start, busy, err, err_code
  );
endinterface

// File: rtl/mxv_load_sequencer.sv
// Frame parser for the UART byte stream: loads size, matrix and vector into
// the data feeder, then starts the compute engine and waits for it to finish.
module mxv_load_sequencer
  import mxv_load_sequencer_pkg::*;
#(
  parameter int         MAX_N = 8,
  parameter logic [7:0] HDR   = 8'hFE,
  parameter logic [7:0] TRL   = 8'hEF
) (
  input logic                   clk,
  input logic                   rst,
  mxv_load_sequencer_if.master  bus
);

  localparam logic [7:0] MAX_N_B = 8'(MAX_N);

  state_t     state;
  logic [7:0] cmd;
  logic [3:0] n;
  logic [3:0] pend_n;
  logic [6:0] nn_target;
  logic [6:0] cnt;
  logic       mat_loaded;
  logic       vec_loaded;

  logic [7:0] rec_data;
  logic       size_m_en;
  logic       enable_mat;
  logic       enable_vec;
  logic       enb_assign;
  logic       clear;
  logic       comp_start;
  logic       busy;
  logic       err;
  logic [2:0] err_code;

  logic [6:0] cnt_next;
  logic [6:0] load_target;

  always_comb begin
    cnt_next    = cnt + 7'd1;
    load_target = (state == LOAD_MAT) ? nn_target : {3'b000, n};
  end

  // N and its square only change when a SIZE frame commits, so a bad or
  // truncated frame never disturbs the dimensions the feeder was set up with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= '0;
      n          <= '0;
      pend_n     <= '0;
      nn_target  <= '0;
      cnt        <= '0;
      mat_loaded <= 1'b0;
      vec_loaded <= 1'b0;
      rec_data   <= '0;
      size_m_en  <= 1'b0;
      enable_mat <= 1'b0;
      enable_vec <= 1'b0;
      enb_assign <= 1'b0;
      clear      <= 1'b0;
      comp_start <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      size_m_en  <= 1'b0;
      enable_mat <= 1'b0;
      enable_vec <= 1'b0;
      clear      <= 1'b0;
      comp_start <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_valid && bus.rx_data == HDR) state <= GET_CMD;
        end

        GET_CMD: begin
          if (bus.rx_valid) begin
            cmd <= bus.rx_data;
            cnt <= '0;
            case (bus.rx_data)
              CMD_SIZE: state <= GET_SIZE;
              CMD_MAT, CMD_VEC: begin
                if (n == 4'd0) begin
                  err      <= 1'b1;
                  err_code <= ERR_NO_SIZE;
                  state    <= IDLE;
                end else begin
                  enb_assign <= 1'b1;
                  state      <= (bus.rx_data == CMD_MAT) ? LOAD_MAT : LOAD_VEC;
                end
              end
              CMD_START, CMD_CLR: state <= GET_TRL;
              default: begin
                err      <= 1'b1;
                err_code <= ERR_BAD_CMD;
                state    <= IDLE;
              end
            endcase
          end
        end

        GET_SIZE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == 8'd0 || bus.rx_data > MAX_N_B) begin
              err      <= 1'b1;
              err_code <= ERR_BAD_SIZE;
              state    <= IDLE;
            end else begin
              pend_n <= bus.rx_data[3:0];
              state  <= GET_TRL;
            end
          end
        end

        LOAD_MAT, LOAD_VEC: begin
          if (bus.rx_valid) begin
            rec_data   <= bus.rx_data;
            enable_mat <= (state == LOAD_MAT);
            enable_vec <= (state == LOAD_VEC);
            cnt        <= cnt_next;
            if (cnt_next == load_target) begin
              enb_assign <= 1'b0;
              state      <= GET_TRL;
            end
          end
        end

        // The trailer is the commit point; a wrong trailer discards the frame.
        GET_TRL: begin
          if (bus.rx_valid) begin
            state <= IDLE;
            if (bus.rx_data != TRL) begin
              err      <= 1'b1;
              err_code <= ERR_BAD_TRL;
            end else begin
              case (cmd)
                CMD_SIZE: begin
                  size_m_en  <= 1'b1;
                  rec_data   <= {4'b0000, pend_n};
                  n          <= pend_n;
                  nn_target  <= mat_target(pend_n);
                  mat_loaded <= 1'b0;
                  vec_loaded <= 1'b0;
                end
                CMD_MAT: mat_loaded <= 1'b1;
                CMD_VEC: vec_loaded <= 1'b1;
                CMD_CLR: begin
                  clear      <= 1'b1;
                  n          <= '0;
                  nn_target  <= '0;
                  mat_loaded <= 1'b0;
                  vec_loaded <= 1'b0;
                end
                CMD_START: begin
                  if (mat_loaded && vec_loaded) begin
                    comp_start <= 1'b1;
                    busy       <= 1'b1;
                    state      <= RUN;
                  end else begin
                    err      <= 1'b1;
                    err_code <= ERR_NOT_LOADED;
                  end
                end
                default: ;
              endcase
            end
          end
        end

        RUN: begin
          if (bus.comp_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          if (bus.rx_valid) begin
            err      <= 1'b1;
            err_code <= ERR_BUSY;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rec_data   = rec_data;
  assign bus.size_m_en  = size_m_en;
  assign bus.enable_mat = enable_mat;
  assign bus.enable_vec = enable_vec;
  assign bus.enb_assign = enb_assign;
  assign bus.clear      = clear;
  assign bus.comp_start = comp_start;
  assign bus.busy       = busy;
  assign bus.err        = err;
  assign bus.err_code   = err_code;

endmodule

// File: tb/tb_mxv_load_sequencer.sv
// Directed frame-level bench for mxv_load_sequencer with hand-computed
// expectations checked by immediate assertions.
module tb_mxv_load_sequencer;

  localparam logic [7:0] P_SIZE  = 8'h20;
  localparam logic [7:0] P_MAT   = 8'h10;
  localparam logic [7:0] P_VEC   = 8'h08;
  localparam logic [7:0] P_CLR   = 8'h04;
  localparam logic [7:0] P_START = 8'h02;
  localparam logic [7:0] P_ERR   = 8'h01;

  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;

  mxv_load_sequencer_if bus ();

  mxv_load_sequencer #(
    .MAX_N (8),
    .HDR   (8'hFE),
    .TRL   (8'hEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pulses();
    return {2'b00, bus.size_m_en, bus.enable_mat, bus.enable_vec,
            bus.clear, bus.comp_start, bus.err};
  endfunction

  // Drives one byte for one cycle; on return the registered response is visible.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
  endtask

  task automatic pulseDone(input logic with_byte, input logic [7:0] b);
    bus.comp_done = 1'b1;
    bus.rx_valid  = with_byte;
    bus.rx_data   = b;
    @(negedge clk);
    bus.comp_done = 1'b0;
    bus.rx_valid  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    assert_cnt    = 0;
    fail_cnt      = 0;
    rst           = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.comp_done = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_pulses", pulses(), 8'h00);
    checkOutput("reset_rec_data", bus.rec_data, 8'h00);
    checkOutput("reset_err_code", {5'b0, bus.err_code}, 8'h00);
    checkOutput("reset_enb_busy", {6'b0, bus.enb_assign, bus.busy}, 8'h00);
    rst = 1'b0;
    idleCycle();

    // SIZE frame N = 3
    applyStimulus(8'hFE);
    applyStimulus(8'h01);
    applyStimulus(8'h03);
    checkOutput("size_before_trl", pulses(), 8'h00);
    applyStimulus(8'hEF);
    checkOutput("size_pulse", pulses(), P_SIZE);
    checkOutput("size_rec_data", bus.rec_data, 8'h03);
    idleCycle();
    checkOutput("size_pulse_single", pulses(), 8'h00);

    // MAT frame, nine back-to-back payload bytes 10..18
    applyStimulus(8'hFE);
    applyStimulus(8'h02);
    checkOutput("mat_enb_rise", {7'b0, bus.enb_assign}, 8'h01);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(8'(8'h0F + i));
      checkOutput("mat_pulse", pulses(), P_MAT);
      checkOutput("mat_rec_data", bus.rec_data, 8'(8'h0F + i));
      checkOutput("mat_enb", {7'b0, bus.enb_assign}, (i < 9) ? 8'h01 : 8'h00);
    end
    applyStimulus(8'hEF);
    checkOutput("mat_trl", pulses(), 8'h00);

    // START with vector missing
    applyStimulus(8'hFE);
    applyStimulus(8'h04);
    applyStimulus(8'hEF);
    checkOutput("start_novec_err", pulses(), P_ERR);
    checkOutput("start_novec_code", {5'b0, bus.err_code}, 8'h04);

    // Oversize N rejected, trailer then falls into IDLE and is discarded
    applyStimulus(8'hFE);
    applyStimulus(8'h01);
    applyStimulus(8'h09);
    checkOutput("bad_size_err", pulses(), P_ERR);
    checkOutput("bad_size_code", {5'b0, bus.err_code}, 8'h03);
    applyStimulus(8'hEF);
    checkOutput("bad_size_trl_ignored", pulses(), 8'h00);

    // VEC frame; N must still be 3
    applyStimulus(8'hFE);
    applyStimulus(8'h03);
    applyStimulus(8'hA1);
    checkOutput("vec_pulse1", pulses(), P_VEC);
    applyStimulus(8'hA2);
    checkOutput("vec_enb_mid", {7'b0, bus.enb_assign}, 8'h01);
    applyStimulus(8'hA3);
    checkOutput("vec_pulse3", pulses(), P_VEC);
    checkOutput("vec_rec_data3", bus.rec_data, 8'hA3);
    checkOutput("vec_enb_fall", {7'b0, bus.enb_assign}, 8'h00);
    applyStimulus(8'hEF);
    checkOutput("vec_trl", pulses(), 8'h00);

    // START, byte during RUN, then comp_done
    applyStimulus(8'hFE);
    applyStimulus(8'h04);
    applyStimulus(8'hEF);
    checkOutput("start_pulse", pulses(), P_START);
    checkOutput("start_busy", {7'b0, bus.busy}, 8'h01);
    idleCycle();
    checkOutput("start_single", pulses(), 8'h00);
    checkOutput("run_busy_hold", {7'b0, bus.busy}, 8'h01);
    applyStimulus(8'h55);
    checkOutput("run_byte_err", pulses(), P_ERR);
    checkOutput("run_byte_code", {5'b0, bus.err_code}, 8'h06);
    checkOutput("run_byte_busy", {7'b0, bus.busy}, 8'h01);
    pulseDone(1'b0, 8'h00);
    checkOutput("done_busy_fall", {7'b0, bus.busy}, 8'h00);

    // Repeat START, then comp_done together with a byte
    applyStimulus(8'hFE);
    applyStimulus(8'h04);
    applyStimulus(8'hEF);
    checkOutput("restart_pulse", pulses(), P_START);
    pulseDone(1'b1, 8'h66);
    checkOutput("done_byte_err", pulses(), P_ERR);
    checkOutput("done_byte_code", {5'b0, bus.err_code}, 8'h06);
    checkOutput("done_byte_busy", {7'b0, bus.busy}, 8'h00);

    // Unknown command
    applyStimulus(8'hFE);
    applyStimulus(8'h07);
    checkOutput("bad_cmd_err", pulses(), P_ERR);
    checkOutput("bad_cmd_code", {5'b0, bus.err_code}, 8'h01);

    // New SIZE clears flags, MAT with bad trailer must not set mat_loaded
    applyStimulus(8'hFE);
    applyStimulus(8'h01);
    applyStimulus(8'h03);
    applyStimulus(8'hEF);
    checkOutput("resize_pulse", pulses(), P_SIZE);
    applyStimulus(8'hFE);
    applyStimulus(8'h02);
    for (int i = 0; i < 9; i++) applyStimulus(8'(8'h30 + i));
    applyStimulus(8'h00);
    checkOutput("bad_trl_err", pulses(), P_ERR);
    checkOutput("bad_trl_code", {5'b0, bus.err_code}, 8'h05);
    applyStimulus(8'hFE);
    applyStimulus(8'h03);
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'h40 + i));
    applyStimulus(8'hEF);
    applyStimulus(8'hFE);
    applyStimulus(8'h04);
    applyStimulus(8'hEF);
    checkOutput("start_nomat_err", pulses(), P_ERR);
    checkOutput("start_nomat_code", {5'b0, bus.err_code}, 8'h04);

    // CLR, then MAT without size
    applyStimulus(8'hFE);
    applyStimulus(8'h05);
    applyStimulus(8'hEF);
    checkOutput("clr_pulse", pulses(), P_CLR);
    applyStimulus(8'hFE);
    applyStimulus(8'h02);
    checkOutput("nosize_err", pulses(), P_ERR);
    checkOutput("nosize_code", {5'b0, bus.err_code}, 8'h02);

    // Reset in the middle of a MAT payload (N = 2)
    applyStimulus(8'hFE);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'hEF);
    applyStimulus(8'hFE);
    applyStimulus(8'h02);
    applyStimulus(8'h77);
    applyStimulus(8'h78);
    checkOutput("pre_rst_pulse", pulses(), P_MAT);
    checkOutput("pre_rst_enb", {7'b0, bus.enb_assign}, 8'h01);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_pulses", pulses(), 8'h00);
    checkOutput("rst_rec_data", bus.rec_data, 8'h00);
    checkOutput("rst_err_code", {5'b0, bus.err_code}, 8'h00);
    checkOutput("rst_enb_busy", {6'b0, bus.enb_assign, bus.busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    idleCycle();
    applyStimulus(8'hFE);
    applyStimulus(8'h02);
    checkOutput("post_rst_err", pulses(), P_ERR);
    checkOutput("post_rst_code", {5'b0, bus.err_code}, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mxv_load_sequencer.md
# mxv_load_sequencer

Frame-level controller for the matrix-vector load path. It parses the UART receive byte stream into command frames, then drives the size, matrix, vector, assign and clear controls of the data feeder. After the matrix and vector are loaded, it starts the compute engine and holds off new frames until that engine reports completion. It sits between the UART receiver and the data feeder/compute block in the top level.

## Interface
Parameters:
- MAX_N, 8: largest legal matrix dimension N.
- HDR, 8'hFE: frame header byte.
- TRL, 8'hEF: frame trailer byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe, received byte on rx_data.
- rx_data  in  8  received byte.
- comp_done  in  1  one-cycle strobe from the compute engine.
- rec_data  out  8  byte forwarded to the feeder.
- size_m_en  out  1  one-cycle pulse: rec_data holds N.
- enable_mat  out  1  one-cycle pulse per matrix byte.
- enable_vec  out  1  one-cycle pulse per vector byte.
- enb_assign  out  1  level, high during the matrix/vector payload phase.
- clear  out  1  one-cycle feeder clear.
- comp_start  out  1  one-cycle compute start.
- busy  out  1  high while in RUN.
- err  out  1  one-cycle error strobe.
- err_code  out  3  code of the last error, held until the next error.

## Operation
- Frame format: HDR, CMD, payload, TRL. The commands are:
  - 0x01 SIZE: 1 payload byte, N.
  - 0x02 MAT: N*N payload bytes.
  - 0x03 VEC: N payload bytes.
  - 0x04 START: no payload.
  - 0x05 CLR: no payload.
- States: IDLE, GET_CMD, GET_SIZE, LOAD_MAT, LOAD_VEC, GET_TRL, RUN. Transitions occur only on an rx_valid byte, except RUN, which exits on comp_done.
- IDLE: non-HDR bytes are discarded silently. HDR goes to GET_CMD.
- GET_CMD dispatch:
  - SIZE goes to GET_SIZE.
  - MAT/VEC go to LOAD_MAT/LOAD_VEC only if N is set (nonzero). Otherwise err, code 2, back to IDLE.
  - START/CLR go to GET_TRL.
  - Any other code: err, code 1, back to IDLE.
- GET_SIZE: the byte is latched as pending N, then the block goes to GET_TRL. If the byte is 0 or greater than MAX_N: err, code 3, back to IDLE.
- LOAD_MAT/LOAD_VEC:
  - enb_assign is high throughout.
  - Each byte produces rec_data = byte plus an enable_mat/enable_vec pulse.
  - A 7-bit payload counter counts up to N*N or N, then the block goes to GET_TRL.
- GET_TRL, trailer byte == TRL:
  - SIZE: size_m_en pulse with rec_data = N. Sets N, clears the mat_loaded and vec_loaded flags.
  - MAT: sets mat_loaded.
  - VEC: sets vec_loaded.
  - CLR: clear pulse. Resets N and both loaded flags.
  - START: if both flags are set, comp_start pulse and go to RUN. Otherwise err, code 4.
- GET_TRL, trailer byte != TRL: err, code 5. No commit; a MAT/VEC load flag stays 0.
- Every path that does not enter RUN returns to IDLE.
- RUN: busy is high. Every rx_valid byte is dropped with err, code 6. comp_done returns the block to IDLE and leaves the flags set, so START may be repeated.
- Simultaneous rx_valid and comp_done in RUN: comp_done wins and the byte is dropped (err, code 6).
- rst at any time: every output and register goes to 0 (rec_data 8'h00, err_code 0), state goes to IDLE, N = 0, flags = 0. No clear pulse is issued; the feeder has its own reset.

## Timing
- All outputs are registered.
- A response to an rx_valid byte appears exactly 1 cycle after that strobe. This applies to the rec_data/enable pulses, size_m_en, clear, comp_start and err.
- comp_start is issued 1 cycle after the START trailer byte.
- busy rises with comp_start and falls 1 cycle after comp_done.
- enb_assign rises 1 cycle after the MAT/VEC command byte and falls 1 cycle after the last payload byte.
- Back-to-back rx_valid (every cycle) is supported with no byte loss.
- The pulse outputs are never high for more than one cycle per causing byte.

## Structure
- Shared package: the state enum, the command codes (CMD_SIZE..CMD_CLR), and the err_code constants 1–6.
- No sub-module. The payload counter and the target comparator (N*N via a 4x4 multiply, registered when N commits) are inline.

## Test plan
- Frame FE 01 03 EF -> one size_m_en with rec_data = 03, 1 cycle after the EF strobe. No err.
- After N = 3, frame FE 02 followed by 9 bytes 10..18, then EF -> nine enable_mat pulses, rec_data 10..18 in order, enb_assign high across them, mat_loaded set.
- Frame FE 03, three bytes, EF, then FE 04 EF -> comp_start 1 cycle after the EF. busy stays high until comp_done; a byte sent during RUN gives err, code 6.
- FE 04 EF with no vector loaded -> err, code 4, no comp_start. FE 01 09 EF with MAX_N = 8 -> err, code 3, N unchanged.
- FE 02 with N = 0 -> err, code 2. FE 07 -> err, code 1. A MAT frame ending in 00 instead of EF -> err, code 5, mat_loaded stays 0.
- rst asserted in the middle of a MAT payload -> all outputs 0 immediately. The next FE 02 frame gives err, code 2.
